// File: rtl/miniled_serial_rx_pkg.sv
// Shared widths, scan row codes and row-FSM states
// for the MiniLED serial receive checker.
package miniled_serial_rx_pkg;

  localparam int DATA_W_D = 16;
  localparam int CNT_W_D  = 8;
  localparam int GCNT_W_D = 16;

  localparam logic [3:0] SCAN_ROW0 = 4'b0001;
  localparam logic [3:0] SCAN_ROW1 = 4'b0010;
  localparam logic [3:0] SCAN_ROW2 = 4'b0100;
  localparam logic [3:0] SCAN_ROW3 = 4'b1000;

  typedef enum logic {
    ROW_IDLE   = 1'b0,
    ROW_ACTIVE = 1'b1
  } row_st_e;

  // Non-one-hot patterns encode to row 0.
  function automatic logic [1:0] scan_enc(
    input logic [3:0] p
  );
    case (p)
      SCAN_ROW0: return 2'd0;
      SCAN_ROW1: return 2'd1;
      SCAN_ROW2: return 2'd2;
      SCAN_ROW3: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic logic scan_onehot(
    input logic [3:0] p
  );
    return (p != 4'd0) &&
           ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/miniled_sync_edge.sv
// 2-FF synchronizer, delay register and registered rise detect.
// Ports: I_clk, I_rst, I_d (async in), O_level (delayed sync), O_rise.
module miniled_sync_edge (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_d,
  output logic O_level,
  output logic O_rise
);

  logic s1;
  logic s2;

  // O_level and O_rise change on the same edge, so a data
  // line synced here lines up with its clock's rise event.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      O_level <= 1'b0;
      O_rise  <= 1'b0;
    end else begin
      s1      <= I_d;
      s2      <= s1;
      O_level <= s2;
      O_rise  <= s2 & ~O_level;
    end
  end

endmodule

// File: rtl/miniled_serial_rx.sv
// MiniLED serial interface receiver: deserializes SDI on DCLK, latches on LE,
// counts GCLK per scan row. Outputs: word/valid/bitcnt/len_err, row report.
module miniled_serial_rx
  import miniled_serial_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CNT_W  = CNT_W_D,
  parameter int GCNT_W = GCNT_W_D
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_le,
  input  logic              I_dclk,
  input  logic              I_sdi,
  input  logic              I_gclk,
  input  logic [3:0]        I_scan,
  output logic [DATA_W-1:0] O_data,
  output logic              O_valid,
  output logic [CNT_W-1:0]  O_bitcnt,
  output logic              O_len_err,
  output logic [1:0]        O_row,
  output logic [GCNT_W-1:0] O_gclk_cnt,
  output logic              O_row_valid,
  output logic              O_row_err
);

  localparam logic [CNT_W-1:0] LEN_OK = CNT_W'(DATA_W);

  logic le_rise, dclk_rise, gclk_rise;
  logic le_lvl, dclk_lvl, gclk_lvl;
  logic sdi_lvl, sdi_rise;
  logic unused_ok;

  miniled_sync_edge u_le (
    .I_clk(I_clk), .I_rst(I_rst), .I_d(I_le),
    .O_level(le_lvl), .O_rise(le_rise));
  miniled_sync_edge u_dclk (
    .I_clk(I_clk), .I_rst(I_rst), .I_d(I_dclk),
    .O_level(dclk_lvl), .O_rise(dclk_rise));
  miniled_sync_edge u_sdi (
    .I_clk(I_clk), .I_rst(I_rst), .I_d(I_sdi),
    .O_level(sdi_lvl), .O_rise(sdi_rise));
  miniled_sync_edge u_gclk (
    .I_clk(I_clk), .I_rst(I_rst), .I_d(I_gclk),
    .O_level(gclk_lvl), .O_rise(gclk_rise));

  assign unused_ok = ^{le_lvl, dclk_lvl, gclk_lvl, sdi_rise};

  // Scan bus: same depth as the 1-bit paths so that a
  // change event coincides with GCLK events of that cycle.
  logic [3:0] sc1, sc2, sc_d, sc_prev, sc_cur;
  logic       sc_chg;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sc1     <= '0;
      sc2     <= '0;
      sc_d    <= '0;
      sc_prev <= '0;
      sc_cur  <= '0;
      sc_chg  <= 1'b0;
    end else begin
      sc1     <= I_scan;
      sc2     <= sc1;
      sc_d    <= sc2;
      sc_prev <= sc_d;
      sc_cur  <= sc2;
      sc_chg  <= (sc2 != sc_d);
    end
  end

  logic [DATA_W-1:0] shift, shift_nx;
  logic [CNT_W-1:0]  bitcnt, bitcnt_nx;

  // Shift first so a coincident LE latches the new bit.
  always_comb begin
    shift_nx  = shift;
    bitcnt_nx = bitcnt;
    if (dclk_rise) begin
      shift_nx = {shift[DATA_W-2:0], sdi_lvl};
      if (bitcnt != '1)
        bitcnt_nx = bitcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      shift     <= '0;
      bitcnt    <= '0;
      O_data    <= '0;
      O_bitcnt  <= '0;
      O_len_err <= 1'b0;
      O_valid   <= 1'b0;
    end else begin
      shift   <= shift_nx;
      O_valid <= le_rise;
      if (le_rise) begin
        O_data    <= shift_nx;
        O_bitcnt  <= bitcnt_nx;
        O_len_err <= (bitcnt_nx != LEN_OK);
        bitcnt    <= '0;
      end else begin
        bitcnt <= bitcnt_nx;
      end
    end
  end

  row_st_e           state;
  logic [GCNT_W-1:0] gcnt, gcnt_inc;

  always_comb begin
    gcnt_inc = gcnt;
    if (gclk_rise && (gcnt != '1))
      gcnt_inc = gcnt + GCNT_W'(1);
  end

  // A GCLK edge coincident with a row change belongs
  // to the new row.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state       <= ROW_IDLE;
      gcnt        <= '0;
      O_row       <= '0;
      O_gclk_cnt  <= '0;
      O_row_err   <= 1'b0;
      O_row_valid <= 1'b0;
    end else begin
      O_row_valid <= 1'b0;
      if (sc_chg)
        gcnt <= gclk_rise ? GCNT_W'(1) : '0;
      else
        gcnt <= gcnt_inc;
      unique case (state)
        ROW_IDLE: begin
          if (sc_cur != 4'd0)
            state <= ROW_ACTIVE;
        end
        ROW_ACTIVE: begin
          if (sc_chg) begin
            O_row       <= scan_enc(sc_prev);
            O_gclk_cnt  <= gcnt;
            O_row_err   <= ~scan_onehot(sc_prev);
            O_row_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miniled_serial_rx.sv
// Directed bench for miniled_serial_rx: words, short/empty/saturated
// latches, coincident edges, row timing, bad scan and mid-word reset.
module tb_miniled_serial_rx;

  logic        clk = 1'b0;
  logic        rst, le, dclk, sdi, gclk;
  logic [3:0]  scan;
  logic [15:0] O_data;
  logic        O_valid;
  logic [7:0]  O_bitcnt;
  logic        O_len_err;
  logic [1:0]  O_row;
  logic [15:0] O_gclk_cnt;
  logic        O_row_valid;
  logic        O_row_err;

  int errs = 0;
  int checks = 0;
  int rv_cnt = 0;
  logic [1:0]  cap_row;
  logic [15:0] cap_g;
  logic        cap_err;

  miniled_serial_rx dut (
    .I_clk(clk), .I_rst(rst), .I_le(le), .I_dclk(dclk),
    .I_sdi(sdi), .I_gclk(gclk), .I_scan(scan),
    .O_data(O_data), .O_valid(O_valid), .O_bitcnt(O_bitcnt),
    .O_len_err(O_len_err), .O_row(O_row),
    .O_gclk_cnt(O_gclk_cnt), .O_row_valid(O_row_valid),
    .O_row_err(O_row_err));

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (O_row_valid) begin
      rv_cnt++;
      cap_row = O_row;
      cap_g   = O_gclk_cnt;
      cap_err = O_row_err;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 12.5 MHz DCLK: 2 cycles low with data set, 2 cycles high.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dclk = 1'b0;
      sdi  = w[i];
      tick(2);
      dclk = 1'b1;
      tick(2);
    end
  endtask

  task automatic pulse_le(input bit with_dclk, input logic b,
                          output int lat, output int width,
                          output logic [15:0] d,
                          output logic [7:0] bc,
                          output logic e);
    lat = 0; width = 0; d = '0; bc = '0; e = 1'b0;
    if (with_dclk) begin
      dclk = 1'b0;
      sdi  = b;
      tick(2);
      dclk = 1'b1;
    end
    le = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (O_valid) begin
        if (width == 0) begin
          lat = i; d = O_data; bc = O_bitcnt; e = O_len_err;
        end
        width++;
      end
    end
    @(negedge clk);
    le = 1'b0;
    tick(4);
  endtask

  task automatic wait_rv(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rv_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic gclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      gclk = 1'b1;
      tick(2);
      gclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; le = 0; dclk = 0; sdi = 0; gclk = 0; scan = '0;
    tick(3);
    checks++; if (O_data !== 16'h0) begin errs++; $display("FAIL rst_data got=%h exp=0", O_data); end
    checks++; if (O_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", O_valid); end
    checks++; if (O_bitcnt !== 8'd0) begin errs++; $display("FAIL rst_bitcnt got=%0d exp=0", O_bitcnt); end
    checks++; if (O_row_valid !== 1'b0 || O_row_err !== 1'b0) begin errs++; $display("FAIL rst_row got=%b%b exp=00", O_row_valid, O_row_err); end
    rst = 1'b0;
    tick(6);
  endtask

  task automatic test_normal;
    int lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    shift_bits(32'hA5C3, 16);
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (lat != 4) begin errs++; $display("FAIL norm_latency got=%0d exp=4", lat); end
    checks++; if (w != 1) begin errs++; $display("FAIL norm_valid_width got=%0d exp=1", w); end
    checks++; if (d !== 16'hA5C3) begin errs++; $display("FAIL norm_data got=%h exp=a5c3", d); end
    checks++; if (bc !== 8'd16) begin errs++; $display("FAIL norm_bitcnt got=%0d exp=16", bc); end
    checks++; if (e !== 1'b0) begin errs++; $display("FAIL norm_len_err got=%b exp=0", e); end
  endtask

  task automatic test_short_word;
    int lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    // Old LSB of A5C3 (1) stays on top of the 15 new bits.
    shift_bits(32'h1234, 15);
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (d !== 16'h9234) begin errs++; $display("FAIL short_data got=%h exp=9234", d); end
    checks++; if (bc !== 8'd15) begin errs++; $display("FAIL short_bitcnt got=%0d exp=15", bc); end
    checks++; if (e !== 1'b1) begin errs++; $display("FAIL short_len_err got=%b exp=1", e); end
    shift_bits(32'h0001, 16);
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (d !== 16'h0001) begin errs++; $display("FAIL follow_data got=%h exp=0001", d); end
    checks++; if (bc !== 8'd16 || e !== 1'b0) begin errs++; $display("FAIL follow_cnt got=%0d/%b exp=16/0", bc, e); end
  endtask

  task automatic test_empty_le;
    int lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (w != 1) begin errs++; $display("FAIL empty_valid got=%0d exp=1", w); end
    checks++; if (bc !== 8'd0 || e !== 1'b1) begin errs++; $display("FAIL empty_cnt got=%0d/%b exp=0/1", bc, e); end
    checks++; if (d !== 16'h0001) begin errs++; $display("FAIL empty_data got=%h exp=0001", d); end
  endtask

  task automatic test_coincident;
    int lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    shift_bits(32'h091A, 15);
    pulse_le(1, 1'b1, lat, w, d, bc, e);
    checks++; if (d !== 16'h1235) begin errs++; $display("FAIL coin_data got=%h exp=1235", d); end
    checks++; if (bc !== 8'd16 || e !== 1'b0) begin errs++; $display("FAIL coin_cnt got=%0d/%b exp=16/0", bc, e); end
  endtask

  task automatic test_saturate;
    int lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    for (int k = 0; k < 10; k++) shift_bits(32'h0BEEF00D, 30);
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (bc !== 8'd255 || e !== 1'b1) begin errs++; $display("FAIL sat_cnt got=%0d/%b exp=255/1", bc, e); end
    checks++; if (d !== 16'hF00D) begin errs++; $display("FAIL sat_data got=%h exp=f00d", d); end
  endtask

  task automatic test_row_timing;
    int base; bit ok;
    base = rv_cnt;
    scan = 4'b0001;
    tick(8);
    gclk_pulses(64);
    tick(4);
    checks++; if (rv_cnt != base) begin errs++; $display("FAIL row_first_suppress got=%0d exp=%0d", rv_cnt, base); end
    scan = 4'b0010;
    wait_rv(base + 1, ok);
    checks++; if (!ok) begin errs++; $display("FAIL row_valid_timeout got=%0d exp=%0d", rv_cnt, base + 1); end
    tick(6);
    checks++; if (rv_cnt != base + 1) begin errs++; $display("FAIL row_valid_count got=%0d exp=%0d", rv_cnt, base + 1); end
    checks++; if (cap_row !== 2'd0) begin errs++; $display("FAIL row_idx got=%0d exp=0", cap_row); end
    checks++; if (cap_g !== 16'd64) begin errs++; $display("FAIL row_gcnt got=%0d exp=64", cap_g); end
    checks++; if (cap_err !== 1'b0) begin errs++; $display("FAIL row_err got=%b exp=0", cap_err); end
  endtask

  task automatic test_bad_scan;
    int base; bit ok;
    base = rv_cnt;
    scan = 4'b0011;
    wait_rv(base + 1, ok);
    tick(4);
    checks++; if (!ok || cap_row !== 2'd1 || cap_g !== 16'd0) begin errs++; $display("FAIL bad_prev_row got=%0d/%0d exp=1/0", cap_row, cap_g); end
    gclk_pulses(10);
    tick(4);
    scan = 4'b0100;
    wait_rv(base + 2, ok);
    checks++; if (!ok) begin errs++; $display("FAIL bad_timeout got=%0d exp=%0d", rv_cnt, base + 2); end
    checks++; if (cap_err !== 1'b1) begin errs++; $display("FAIL bad_err got=%b exp=1", cap_err); end
    checks++; if (cap_row !== 2'd0 || cap_g !== 16'd10) begin errs++; $display("FAIL bad_row got=%0d/%0d exp=0/10", cap_row, cap_g); end
    tick(10);
    checks++; if (O_row_err !== 1'b1) begin errs++; $display("FAIL bad_err_hold got=%b exp=1", O_row_err); end
  endtask

  task automatic test_reset_mid;
    int base, lat, w; logic [15:0] d; logic [7:0] bc; logic e;
    shift_bits(32'hFF, 8);
    dclk = 1'b0;
    rst  = 1'b1;
    #1;
    checks++; if (O_data !== 16'h0 || O_bitcnt !== 8'd0 || O_len_err !== 1'b0) begin errs++; $display("FAIL rmid_word got=%h/%0d/%b exp=0/0/0", O_data, O_bitcnt, O_len_err); end
    checks++; if (O_row_err !== 1'b0 || O_gclk_cnt !== 16'd0 || O_row !== 2'd0) begin errs++; $display("FAIL rmid_row got=%b/%0d/%0d exp=0/0/0", O_row_err, O_gclk_cnt, O_row); end
    tick(3);
    rst = 1'b0;
    base = rv_cnt;
    tick(10);
    checks++; if (rv_cnt != base) begin errs++; $display("FAIL rmid_idle_row got=%0d exp=%0d", rv_cnt, base); end
    shift_bits(32'hFFFF, 16);
    pulse_le(0, 0, lat, w, d, bc, e);
    checks++; if (d !== 16'hFFFF) begin errs++; $display("FAIL rmid_data got=%h exp=ffff", d); end
    checks++; if (bc !== 8'd16 || e !== 1'b0) begin errs++; $display("FAIL rmid_cnt got=%0d/%b exp=16/0", bc, e); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short_word();
    test_empty_le();
    test_coincident();
    test_saturate();
    test_row_timing();
    test_bad_scan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
